// File: rtl/mac_accumulator.sv
// Multiply-accumulate back end: sums len extended 16-bit products and
// returns the sum with a sticky overflow flag on a valid/ready port.
module mac_accumulator #(
    parameter int ACC_W = 18,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             mode,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt, len_q;
    logic               mode_q, ovf;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W:0]     sum;
    logic               add_ovf, xfer, last;

    // Signed cast extends from bit 15; unsigned cast zero-fills.
    assign ext  = mode_q ? ACC_W'($signed(prod_data)) : ACC_W'(prod_data);
    assign sum  = {1'b0, acc} + {1'b0, ext};
    assign add_ovf = mode_q ? ((acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                            : sum[ACC_W];
    assign xfer = prod_valid && prod_ready;
    assign last = (cnt == len_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (xfer && last) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (state == ACCUM);
        res_valid  = (state == DONE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == IDLE && start) begin
            acc    <= '0;
            cnt    <= '0;
            len_q  <= len;
            mode_q <= mode;
            ovf    <= 1'b0;
        end else if (state == ACCUM && xfer) begin
            acc <= sum[ACC_W-1:0];
            cnt <= cnt + CNT_W'(1);
            if (add_ovf) ovf <= 1'b1;
        end
    end

    // Outputs come straight from state registers; no input reaches them.
    assign res_data = acc;
    assign res_ovf  = ovf;

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Accumulation stage directly downstream of the 8-bit multiplier unit. It consumes one 16-bit product per handshake from `mul_out`.
- The product is sign-extended or zero-extended per the multiply mode, then summed over a programmed number of products.
- The final sum and a sticky overflow flag are presented on a valid/ready result port.
- Forms the back end of the ALU's multiply-accumulate path.

Parameters:
- ACC_W, 18: accumulator and result width in bits. Must be at least 16.
- CNT_W, 4: width of the product-count field.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  CNT_W  number of products to accumulate; latched on start.
- mode  in  1  0 = unsigned, 1 = signed. Same encoding as the multiplier's `mul_sel`. Latched on start.
- prod_valid  in  1  the product on prod_data is valid.
- prod_ready  out  1  the block accepts a product this cycle.
- prod_data  in  16  product from the multiplier.
- res_valid  out  1  result is available.
- res_ready  in  1  the consumer accepts the result.
- res_data  out  ACC_W  accumulated sum, modulo 2^ACC_W.
- res_ovf  out  1  sticky overflow flag for the current accumulation.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; acc, cnt, len_q, mode_q and ovf all clear to 0.
  - prod_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0 from the cycle after rst is sampled high.
  - Reset mid-operation abandons the accumulation with no result produced, and takes priority over every other event.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - prod_ready=0, res_valid=0.
  - On start=1: latch len and mode; acc<=0, cnt<=0, ovf<=0.
  - Next state is DONE if len==0, otherwise ACCUM.
  - With start=1 and len==0, the result is 0 with ovf=0.
- ACCUM:
  - prod_ready=1, driven combinationally from state only; it does not depend on prod_valid.
  - A transfer occurs when prod_valid && prod_ready.
  - On each transfer: acc <= acc + ext(prod_data) and cnt <= cnt+1.
  - ext() is zero-extension to ACC_W when mode_q=0 and sign-extension from bit 15 when mode_q=1.
  - Overflow sets ovf, and ovf stays set until the next start or reset:
    - Unsigned: carry out of bit ACC_W-1.
    - Signed: both addends have the same sign and the sum's sign differs.
  - A transfer with cnt==len_q-1 moves to DONE on the next edge. The last product is included in acc.
  - Cycles with prod_valid=0 leave all state unchanged.
  - start is ignored outside IDLE.
- DONE:
  - res_valid=1, res_data=acc, res_ovf=ovf, prod_ready=0.
  - Outputs stay stable while res_ready=0.
  - On res_ready=1: return to IDLE next edge. res_valid drops in that cycle.
  - A start asserted in the same cycle as the DONE->IDLE handshake is ignored; start is taken only when already in IDLE.
- Latency:
  - The first product can be accepted one cycle after start.
  - res_valid asserts one cycle after the final product transfer.
  - Minimum start-to-res_valid time is len+1 cycles.
- res_data and res_ovf are registered outputs, with no combinational path from any input.
- Arithmetic wraps modulo 2^ACC_W; only res_ovf reports the wrap.

Test Plan:
- Unsigned sum: start, len=3, mode=0; three products 0xFFFF with prod_valid held high -> res_valid on the 4th cycle after start acceptance, res_data=0x2FFFD, res_ovf=0.
- Signed sum: len=2, mode=1; products 0xFF80 and 0xFF80 (-128 each) -> res_data=0x3FF00 (-256), res_ovf=0.
- Overflow:
  - Unsigned: len=5, mode=0, five products 0xFFFF -> res_data=0x0FFFB, res_ovf=1.
  - Signed: len=9, mode=1, nine products 0x4000 -> res_data=0x24000, res_ovf=1.
- Backpressure:
  - len=2 with product 0x0001; prod_valid toggled 1,0,0,1 -> exactly 2 transfers counted, res_data=0x00002.
  - res_ready held 0 for 5 cycles -> res_valid and res_data unchanged, busy=1; then res_ready=1 -> IDLE next cycle, busy=0.
- Boundary:
  - len=0 -> DONE one cycle after start, res_data=0.
  - start pulsed during ACCUM -> ignored, with count and sum unaffected.
- Reset mid-op: after 2 of 4 products, assert rst for 1 cycle -> all outputs 0 next cycle, state IDLE. A new start with len=1 and product 0x0007 -> res_data=0x00007, res_ovf=0.
